phys_reg_free_list: RTL
=======================

// Module: phys_reg_free_list
// PURPOSE
//  Free list of physical registers for the renamer. Consumer of the retire packet and
//  decode-stage rename info produced by ID management. Allocates a new phys rd at decode.
//  Records the displaced (old) phys mapping per ID. Returns that old register to the list
//  when the ID retires with rd. Also accepts registers returned by flush rollback.
// PARAMETERS
//  NUM_PHYS  64  total physical registers (power of 2); PHYS_W = $clog2(NUM_PHYS)
//  NUM_ARCH  32  arch regs mapped at reset (phys 0..NUM_ARCH-1 never initially free)
//  MAX_IDS   8   instruction IDs in flight (power of 2); ID_W = $clog2(MAX_IDS)
// PORTS
//  clk                 in   1         clock
//  rst                 in   1         synchronous, active-high reset
//  decode_advance      in   1         decode instruction accepted this cycle
//  decode_id           in   ID_W      ID of decoding instruction
//  decode_uses_rd      in   1         decoding instruction writes a renamed rd
//  decode_old_phys     in   PHYS_W    phys reg currently mapped to its rd (displaced)
//  retire_valid        in   1         retire packet: an rd-writing ID retired
//  retire_phys_id      in   ID_W      retire packet: ID of that instruction
//  rollback_valid      in   1         speculative allocation being returned
//  rollback_phys       in   PHYS_W    register returned by rollback
//  alloc_req           in   1         pop head this cycle
//  alloc_available     out  1         head valid, pop permitted
//  alloc_phys          out  PHYS_W    head of free list
//  free_count          out  PHYS_W+1  registers currently free
//  init_done           out  1         initialisation complete
//  double_free_error   out  1         sticky error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Storage: circular FIFO, depth NUM_PHYS, rd/wr pointers PHYS_W bits, natural wrap.
//  - old_phys table, MAX_IDS x PHYS_W: written [decode_id] <= decode_old_phys when
//    decode_advance & decode_uses_rd; otherwise unchanged.
//  - FSM INIT -> RUN. Reset forces INIT, ptrs=0, count=0, init_cnt=NUM_ARCH; all outputs 0.
//    INIT: each cycle write init_cnt at wr_ptr, wr_ptr++, count++, init_cnt++.
//    After writing NUM_PHYS-1 go RUN. Fills in NUM_PHYS-NUM_ARCH cycles.
//    init_done=1 from the first RUN cycle. rst asserted mid-INIT restarts INIT from NUM_ARCH.
//    In INIT, alloc_req/retire/rollback are ignored (assertion flags them).
//  - Retire path, 1 cycle latency: cycle N register retire_valid and
//    old_phys[retire_phys_id] (read in cycle N). Cycle N+1 push if valid.
//    Entry visible in free_count at N+2.
//  - Rollback path: rollback_phys pushed in the same cycle it is presented.
//  - Two pushes per cycle allowed. Ordering: retire entry at wr_ptr, rollback at wr_ptr+1.
//  - Any push of phys 0 is dropped (x0 never renamed) and does not count.
//  - alloc_available = init_done & (free_count != 0), from registered count only; no
//    push->pop bypass. Pop: rd_ptr++, count--.
//    alloc_req with !alloc_available: ignored, no state change, assertion fires.
//  - count_next = count + pushes - pop, all in one cycle. Overflow beyond NUM_PHYS is
//    impossible by construction; assertion checks count <= NUM_PHYS-NUM_ARCH.
//  - alloc_phys = fifo[rd_ptr] (comb read). Value undefined while !alloc_available.
// CONFIGURATION
//  FREE_LIST_DOUBLE_FREE_CHECK_EN defined:
//    - Keep a NUM_PHYS-bit is_free bitmap: set on push, cleared on pop, set for init entries.
//    - Pushing a reg already free, or popping a reg not free, sets double_free_error (sticky).
//    - Only rst clears it; the offending push is still performed.
//  Not defined: bitmap and checks omitted; double_free_error tied 0.
// TESTING
//  - Reset 1 cycle, NUM_PHYS=64, NUM_ARCH=32.
//    -> init_done=1 after 32 cycles; free_count=32; alloc_phys=32.
//  - 32 back-to-back alloc_req -> alloc_phys 32..63 in order; free_count=0; alloc_available=0.
//    An extra alloc_req -> no change.
//  - decode id3 old_phys=5; later retire id3 on cycle N -> free_count +1 at N+2.
//    After draining, 5 is popped last.
//  - retire(old 7) pushed in the same cycle as rollback_phys=40 -> free_count +2.
//    Pop order 7 then 40.
//  - Push phys 0 via rollback -> free_count unchanged.
//  - With FREE_LIST_DOUBLE_FREE_CHECK_EN: rollback of free reg 33 after init -> error=1 and
//    stays 1 until rst. Assert rst mid-INIT -> init restarts; final free_count=32.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free phys regs, fed by retire and rollback.
// Optional FREE_LIST_DOUBLE_FREE_CHECK_EN adds an is_free bitmap and a sticky double-free flag.
module phys_reg_free_list #(
  parameter  int unsigned NUM_PHYS = 64,
  parameter  int unsigned NUM_ARCH = 32,
  parameter  int unsigned MAX_IDS  = 8,
  localparam int unsigned PHYS_W   = $clog2(NUM_PHYS),
  localparam int unsigned ID_W     = $clog2(MAX_IDS),
  localparam int unsigned CNT_W    = PHYS_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              decode_advance,
  input  logic [ID_W-1:0]   decode_id,
  input  logic              decode_uses_rd,
  input  logic [PHYS_W-1:0] decode_old_phys,
  input  logic              retire_valid,
  input  logic [ID_W-1:0]   retire_phys_id,
  input  logic              rollback_valid,
  input  logic [PHYS_W-1:0] rollback_phys,
  input  logic              alloc_req,
  output logic              alloc_available,
  output logic [PHYS_W-1:0] alloc_phys,
  output logic [CNT_W-1:0]  free_count,
  output logic              init_done,
  output logic              double_free_error
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [PHYS_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PHYS_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PHYS_W-1:0] init_cnt_q, init_cnt_d;
  logic [PHYS_W-1:0] fifo_q [NUM_PHYS];
  logic [PHYS_W-1:0] fifo_d [NUM_PHYS];
  logic [PHYS_W-1:0] old_phys_q [MAX_IDS];
  logic [PHYS_W-1:0] old_phys_d [MAX_IDS];
  logic              ret_valid_q, ret_valid_d;
  logic [PHYS_W-1:0] ret_phys_q, ret_phys_d;
  logic              ret_push, rb_push, pop;
  logic [PHYS_W-1:0] rb_slot;

  assign init_done       = (state_q == ST_RUN);
  assign alloc_available = init_done && (count_q != '0);
  assign alloc_phys      = fifo_q[rd_ptr_q];
  assign free_count      = count_q;

  // Displaced mapping per in-flight ID, consumed at retire
  always_comb begin
    old_phys_d = old_phys_q;
    if (decode_advance && decode_uses_rd) old_phys_d[decode_id] = decode_old_phys;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    init_cnt_d  = init_cnt_q;
    fifo_d      = fifo_q;
    ret_valid_d = 1'b0;
    ret_phys_d  = ret_phys_q;
    ret_push    = 1'b0;
    rb_push     = 1'b0;
    pop         = 1'b0;
    rb_slot     = wr_ptr_q;
    case (state_q)
      ST_INIT: begin
        fifo_d[wr_ptr_q] = init_cnt_q;
        wr_ptr_d         = wr_ptr_q + PHYS_W'(1);
        count_d          = count_q + CNT_W'(1);
        init_cnt_d       = init_cnt_q + PHYS_W'(1);
        if (init_cnt_q == PHYS_W'(NUM_PHYS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        ret_valid_d = retire_valid;
        ret_phys_d  = old_phys_q[retire_phys_id];
        // x0 is never renamed, so a returned phys 0 is discarded
        ret_push    = ret_valid_q && (ret_phys_q != '0);
        rb_push     = rollback_valid && (rollback_phys != '0);
        pop         = alloc_req && alloc_available;
        rb_slot     = wr_ptr_q + PHYS_W'(ret_push);
        if (ret_push) fifo_d[wr_ptr_q] = ret_phys_q;
        if (rb_push)  fifo_d[rb_slot]  = rollback_phys;
        if (pop)      rd_ptr_d = rd_ptr_q + PHYS_W'(1);
        wr_ptr_d = wr_ptr_q + PHYS_W'(ret_push) + PHYS_W'(rb_push);
        count_d  = count_q + CNT_W'(ret_push) + CNT_W'(rb_push) - CNT_W'(pop);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      init_cnt_q  <= PHYS_W'(NUM_ARCH);
      ret_valid_q <= 1'b0;
      ret_phys_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      init_cnt_q  <= init_cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_phys_q  <= ret_phys_d;
    end
  end

  // Storage arrays carry no reset; pointers and count define their validity
  always_ff @(posedge clk) begin
    fifo_q     <= fifo_d;
    old_phys_q <= old_phys_d;
  end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHYS-1:0] is_free_q, is_free_d;
  logic                dfe_q, dfe_d;

  // Checks use the start-of-cycle bitmap; the offending push still goes through
  always_comb begin
    is_free_d = is_free_q;
    dfe_d     = dfe_q;
    if (state_q == ST_INIT) is_free_d[init_cnt_q] = 1'b1;
    if (pop) begin
      if (!is_free_q[alloc_phys]) dfe_d = 1'b1;
      is_free_d[alloc_phys] = 1'b0;
    end
    if (ret_push) begin
      if (is_free_q[ret_phys_q]) dfe_d = 1'b1;
      is_free_d[ret_phys_q] = 1'b1;
    end
    if (rb_push) begin
      if (is_free_q[rollback_phys] || (ret_push && (ret_phys_q == rollback_phys))) dfe_d = 1'b1;
      is_free_d[rollback_phys] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_free_q <= '0;
      dfe_q     <= 1'b0;
    end else begin
      is_free_q <= is_free_d;
      dfe_q     <= dfe_d;
    end
  end

  assign double_free_error = dfe_q;
`else
  assign double_free_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(NUM_PHYS - NUM_ARCH))
        else $error("free list count exceeds free pool size");
      assert ((state_q == ST_RUN) || !(alloc_req || retire_valid || rollback_valid))
        else $error("request during free list init ignored");
      assert (!alloc_req || alloc_available)
        else $error("alloc_req with no free register ignored");
    end
  end

endmodule
